burst_ram: RTL

Behavioural and synthesizable burst-mode RAM responder that terminates the burst-RAM command interface driven by the instruction and data caches. It accepts one read or write command at a time and streams a fixed-length burst of wide words back to, or in from, the initiator. Read latency and post-reset initialization delay are programmable, so cache controllers can be verified against realistic DDR/PSRAM controller timing.

---
 rtl/burst_ram_if.sv | 25 ++
 rtl/burst_ram.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/burst_ram_if.sv
// Burst-RAM command interface between a cache controller (master) and the
// burst_ram responder (slave).
interface burst_ram_if #(
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned DEPTH_BITWIDTH = 8
) ();
  logic                         cmd;
  logic                         cmd_en;
  logic [DEPTH_BITWIDTH-1:0]    addr;
  logic [DATA_BITWIDTH-1:0]     wr_data;
  logic [DATA_BITWIDTH/8-1:0]   data_mask;
  logic [DATA_BITWIDTH-1:0]     rd_data;
  logic                         rd_data_valid;
  logic                         busy;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, busy
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, busy
  );
endinterface

// File: rtl/burst_ram.sv
// Burst-mode RAM responder: one read or write command at a time, fixed-length
// bursts, programmable read latency and post-reset init delay.
module burst_ram #(
  parameter int unsigned DATA_BITWIDTH            = 64,
  parameter int unsigned DEPTH_BITWIDTH           = 8,
  parameter int unsigned BURST_COUNT              = 4,
  parameter int unsigned CYCLES_BEFORE_DATA_VALID = 6,
  parameter int unsigned CYCLES_BEFORE_INITIATED  = 10,
  parameter string       DATA_FILE                = ""
) (
  input logic       clk,
  input logic       rst,
  burst_ram_if.slave bus
);
  localparam int unsigned BYTES  = DATA_BITWIDTH / 8;
  localparam int unsigned DEPTH  = 1 << DEPTH_BITWIDTH;
  localparam int unsigned LAT    = CYCLES_BEFORE_DATA_VALID;
  localparam int unsigned INIT   = CYCLES_BEFORE_INITIATED;
  localparam int unsigned BEAT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int unsigned LAT_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned INIT_W = (INIT > 1) ? $clog2(INIT) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((INIT > 0) ? INIT - 1 : 0);

  typedef enum logic [2:0] {INIT_S, IDLE, READ_WAIT, READ_BURST, WRITE_BURST} state_t;

  state_t                    state;
  logic [INIT_W-1:0]         init_cnt;
  logic [LAT_W-1:0]          lat_cnt;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [DEPTH_BITWIDTH-1:0] addr_q;
  logic [DATA_BITWIDTH-1:0]  rd_data;
  logic                      rd_data_valid;
  logic                      busy;
  logic                      we;
  logic [DEPTH_BITWIDTH-1:0] waddr;

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];

  assign bus.rd_data       = rd_data;
  assign bus.rd_data_valid = rd_data_valid;
  assign bus.busy          = busy;

  // Beat 0 is written in the accept cycle straight from the bus; later beats follow addr_q.
  always_comb begin
    we    = 1'b0;
    waddr = bus.addr;
    if (!rst) begin
      unique case (state)
        IDLE:        we = bus.cmd_en & bus.cmd;
        WRITE_BURST: begin
          we    = 1'b1;
          waddr = addr_q;
        end
        default: ;
      endcase
    end
  end

  // Mask bit 0 guards the most significant byte of the beat.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (we && !bus.data_mask[i])
        mem[waddr][DATA_BITWIDTH-8*(i+1) +: 8] <= bus.wr_data[DATA_BITWIDTH-8*(i+1) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= (INIT > 0) ? INIT_S : IDLE;
      busy          <= (INIT > 0);
      init_cnt      <= '0;
      lat_cnt       <= '0;
      beat_cnt      <= '0;
      addr_q        <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      unique case (state)
        INIT_S: begin
          if (init_cnt == INIT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.cmd_en) begin
            busy     <= 1'b1;
            beat_cnt <= '0;
            if (bus.cmd) begin
              state    <= WRITE_BURST;
              beat_cnt <= BEAT_W'(1);
              addr_q   <= bus.addr + 1'b1;
            end else if (LAT == 1) begin
              state         <= READ_BURST;
              rd_data       <= mem[bus.addr];
              rd_data_valid <= 1'b1;
              addr_q        <= bus.addr + 1'b1;
            end else begin
              state   <= READ_WAIT;
              lat_cnt <= LAT_W'(1);
              addr_q  <= bus.addr;
            end
          end
        end
        // lat_cnt counts the accept cycle as 1, so beat 0 is launched at count L-1.
        READ_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state         <= READ_BURST;
            rd_data       <= mem[addr_q];
            rd_data_valid <= 1'b1;
            addr_q        <= addr_q + 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        READ_BURST: begin
          if (beat_cnt == BEAT_LAST) begin
            state         <= IDLE;
            busy          <= 1'b0;
            rd_data_valid <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            rd_data  <= mem[addr_q];
            addr_q   <= addr_q + 1'b1;
          end
        end
        WRITE_BURST: begin
          if (beat_cnt == BEAT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            addr_q   <= addr_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
